// File: rtl/ysyx_22040088_ifu_if.sv
// Fetch-unit bus: instruction-memory request/response channels plus the decode-side
// handshake and the optional performance counters (see YSYX_22040088_IFU_PERF_EN).
interface ysyx_22040088_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        branch;
  logic [63:0] branchpc;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_flush_cnt;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  stall, branch, branchpc,
    output id_valid, id_pc, id_inst, perf_fetch_cnt, perf_flush_cnt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output stall, branch, branchpc,
    input  id_valid, id_pc, id_inst, perf_fetch_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: credit-limited in-order fetch into a small FIFO, with redirect/drain.
// Optional delivery/redirect counters are built when YSYX_22040088_IFU_PERF_EN is defined.
module ysyx_22040088_ifu #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_22040088_ifu_if.master bus
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_r, state_nxt;
  logic [63:0]   fetch_pc_r, resp_pc_r;
  logic [CW-1:0] outstanding_r, drop_cnt_r, count_r, drop_cnt_nxt;
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [63:0]   pc_mem_r   [FIFO_DEPTH];
  logic [31:0]   inst_mem_r [FIFO_DEPTH];

  logic valid_s, credit_s, redirect_s, accept_s, push_s, pop_s, req_valid_s, clear_s;
  logic unused_s;

  assign clear_s    = rst || (state_r == S_RESET);
  assign valid_s    = |count_r;
  assign credit_s   = ({1'b0, outstanding_r} + {1'b0, count_r}) < DEPTH;
  assign redirect_s = (state_r == S_FETCH) && bus.branch && valid_s && !bus.stall;
  assign accept_s   = req_valid_s && bus.imem_req_ready;
  // A response is kept only when nothing is left to drop and no flush happens this cycle.
  assign push_s     = bus.imem_resp_valid && !(|drop_cnt_r) && !redirect_s && !clear_s;
  assign pop_s      = valid_s && !bus.stall;
  assign unused_s   = ^bus.branchpc[1:0];

  // Responses still owed to discarded requests.
  always_comb begin
    drop_cnt_nxt = drop_cnt_r;
    if (redirect_s) begin
      drop_cnt_nxt = outstanding_r - CW'(bus.imem_resp_valid);
    end else if (bus.imem_resp_valid && (|drop_cnt_r)) begin
      drop_cnt_nxt = drop_cnt_r - CW'(1'b1);
    end else begin
      drop_cnt_nxt = drop_cnt_r;
    end
  end

  // Fetch FSM next-state and request-valid decode.
  always_comb begin
    state_nxt   = state_r;
    req_valid_s = 1'b0;
    case (state_r)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        if (redirect_s) begin
          state_nxt = (|drop_cnt_nxt) ? S_DRAIN : S_FETCH;
        end else begin
          req_valid_s = credit_s && !rst;
        end
      end
      S_DRAIN: begin
        if (|drop_cnt_nxt) begin
          state_nxt = S_DRAIN;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_nxt;
    end
  end

  // PC, credit and FIFO bookkeeping; the RESET state holds everything cleared.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      count_r       <= {CW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
    end else begin
      drop_cnt_r    <= drop_cnt_nxt;
      outstanding_r <= outstanding_r + CW'(accept_s) - CW'(bus.imem_resp_valid);
      if (redirect_s) begin
        fetch_pc_r <= {bus.branchpc[63:2], 2'b00};
        resp_pc_r  <= {bus.branchpc[63:2], 2'b00};
        count_r    <= {CW{1'b0}};
        rd_ptr_r   <= {AW{1'b0}};
        wr_ptr_r   <= {AW{1'b0}};
      end else begin
        if (accept_s) fetch_pc_r <= fetch_pc_r + 64'd4;
        if (push_s) begin
          resp_pc_r <= resp_pc_r + 64'd4;
          wr_ptr_r  <= wr_ptr_r + AW'(1'b1);
        end
        if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
        count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
    end
  end

  // FIFO storage; the PC of each kept response follows the in-order response PC.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= resp_pc_r;
      inst_mem_r[wr_ptr_r] <= bus.imem_resp_data;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.id_valid       = valid_s;
  assign bus.id_pc          = valid_s ? pc_mem_r[rd_ptr_r] : 64'h0;
  assign bus.id_inst        = valid_s ? inst_mem_r[rd_ptr_r] : NOP;

`ifdef YSYX_22040088_IFU_PERF_EN
  logic [63:0] perf_fetch_r, perf_flush_r;

  // Delivered-instruction and redirect counters, wrapping.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      perf_fetch_r <= 64'h0;
      perf_flush_r <= 64'h0;
    end else begin
      perf_fetch_r <= perf_fetch_r + 64'(pop_s);
      perf_flush_r <= perf_flush_r + 64'(redirect_s);
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_r;
  assign bus.perf_flush_cnt = perf_flush_r;
`else
  assign bus.perf_fetch_cnt = 64'h0;
  assign bus.perf_flush_cnt = 64'h0;
`endif
endmodule
